// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler
// Description : Time-multiplexes a 4-digit seven-segment display. Each digit
//               is selected for REFRESH_DIV cycles. New values arrive through
//               a load handshake and are committed only at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dots_in,
  output logic        busy,
  output logic        ack,
  output logic        frame_done,
  output logic [1:0]  seg_select_out,
  output logic [3:0]  bin_out,
  output logic        dot_out
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        dig;
  logic [15:0]       pend_value;
  logic [3:0]        pend_dots;
  logic [15:0]       comm_value;
  logic [3:0]        comm_dots;
  logic              boundary;
  logic              capture;
  logic              commit;

  // Last cycle of digit 3's slot marks the end of a frame.
  assign boundary = (cnt == CNT_MAX) && (dig == 2'd3);

  // Slot counter and digit index free-run regardless of the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake strobes; the commit decision uses the state at
  // the start of the cycle, so a load taken on a boundary waits a full frame.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (boundary) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending registers hold the submitted value until the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= 16'h0000;
      pend_dots  <= 4'b0000;
    end else if (capture) begin
      pend_value <= value_in;
      pend_dots  <= dots_in;
    end
  end

  // Committed registers feed the display; ACK pulses after each commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      comm_value <= 16'h0000;
      comm_dots  <= 4'b0000;
      ack        <= 1'b0;
    end else begin
      ack <= commit;
      if (commit) begin
        comm_value <= pend_value;
        comm_dots  <= pend_dots;
      end
    end
  end

  // Digit nibble selection from the committed value only.
  always_comb begin
    bin_out = comm_value[3:0];
    case (dig)
      2'd0:    bin_out = comm_value[3:0];
      2'd1:    bin_out = comm_value[7:4];
      2'd2:    bin_out = comm_value[11:8];
      default: bin_out = comm_value[15:12];
    endcase
  end

  assign busy           = (state == PENDING);
  assign frame_done     = boundary;
  assign seg_select_out = dig;
  assign dot_out        = ~comm_dots[dig];

endmodule
`default_nettype wire
